scaler_wrbuf_ctrl: RTL and testbench



---
 rtl/scaler_wrbuf_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_scaler_wrbuf_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_wrbuf_ctrl.sv
// Scaler-to-DDR write-buffer controller: burst padding, round-robin line FIFOs.
// Optional FIFO overflow detection with `define SCALER_WRBUF_OVF_EN.
module scaler_wrbuf_ctrl #(
  parameter int DW    = 24,
  parameter int NBUF  = 2,
  parameter int BURST = 8,
  parameter int XW    = 11,
  parameter int YW    = 12,
  parameter int PIPE  = 3,
  localparam int SW   = (NBUF > 1) ? $clog2(NBUF) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            din_valid,
  input  logic [DW-1:0]   din,
  input  logic [XW-1:0]   line_pix,
  input  logic            interlace_flag,
  input  logic [YW-1:0]   VGA_HV_In,
  input  logic [YW-1:0]   VGA_VV_In,
  input  logic [YW-1:0]   VGA_HV_Out,
  input  logic [YW-1:0]   VGA_VV_Out,
  input  logic [NBUF-1:0] buf_full,
  output logic [XW-1:0]   DDR_WrRow_Start,
  output logic [XW-1:0]   DDR_WrCol_Start,
  output logic [NBUF-1:0] buf_wrreq,
  output logic [DW-1:0]   wr_dat,
  output logic [SW-1:0]   buf_sel,
  output logic            line_done,
  output logic [YW-1:0]   line_idx,
  output logic            overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_PAD,
    S_SWITCH
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   lpix_q, lpix_d;
  logic [XW-1:0]   len_q, len_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [YW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [XW-1:0]   row_q, row_d;
  logic [XW-1:0]   col_q, col_d;

  logic [XW:0]     len_ext;
  logic [XW-1:0]   len_new;
  logic [XW-1:0]   cnt_inc;
  logic            wr_want;
  logic            wr_en;
  logic            drop;
  logic [DW-1:0]   wr_data;
  logic [NBUF-1:0] sel_oh;
  logic [NBUF-1:0] tgt;
  logic [NBUF-1:0] req_d;
  logic [DW-1:0]   dat_d;

  logic [NBUF-1:0] req_q [PIPE];
  logic [DW-1:0]   dat_q [PIPE];

  // Round up to the next burst multiple; BURST is a power of two.
  assign len_ext = ({1'b0, line_pix} + (XW+1)'(BURST - 1))
                 & ~((XW+1)'(BURST - 1));
  assign len_new = len_ext[XW-1:0];
  assign cnt_inc = cnt_q + XW'(1);
  assign sel_oh  = NBUF'(1) << sel_q;
  assign tgt     = interlace_flag ? '1 : sel_oh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lpix_d  = lpix_q;
    len_d   = len_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    wr_want = 1'b0;
    wr_data = '0;
    drop    = 1'b0;
    if (start) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sel_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (din_valid && line_pix != '0) begin
            wr_want = 1'b1;
            wr_data = din;
            cnt_d   = XW'(1);
            lpix_d  = line_pix;
            len_d   = len_new;
            state_d = (line_pix == XW'(1)) ? S_PAD : S_LINE;
          end
        end
        S_LINE: begin
          if (din_valid) begin
            wr_want = 1'b1;
            wr_data = din;
            cnt_d   = cnt_inc;
            if (cnt_inc == lpix_q)
              state_d = (lpix_q == len_q) ? S_SWITCH : S_PAD;
          end
        end
        S_PAD: begin
          wr_want = 1'b1;
          cnt_d   = cnt_inc;
          drop    = din_valid;
          if (cnt_inc == len_q)
            state_d = S_SWITCH;
        end
        S_SWITCH: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          drop    = din_valid;
        end
      endcase
      if (state_d == S_SWITCH) begin
        done_d = 1'b1;
        idx_d  = idx_q + YW'(1);
        sel_d  = (sel_q == SW'(NBUF - 1)) ? '0 : sel_q + SW'(1);
      end
    end
  end

`ifdef SCALER_WRBUF_OVF_EN
  logic blocked;
  assign blocked = |(tgt & buf_full);
  assign wr_en   = wr_want & ~blocked;
  always_comb begin
    ovf_d = ovf_q;
    if (start)
      ovf_d = 1'b0;
    else if ((wr_want & blocked) | drop)
      ovf_d = 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{buf_full, drop};
  assign wr_en      = wr_want;
  assign ovf_d      = 1'b0;
`endif

  assign req_d = wr_en ? tgt : '0;
  assign dat_d = wr_en ? wr_data : '0;

  always_comb begin
    row_d = (VGA_VV_Out >= VGA_VV_In)
          ? XW'((VGA_VV_Out - VGA_VV_In) >> 1) : '0;
    col_d = (VGA_HV_Out >= VGA_HV_In)
          ? XW'((VGA_HV_Out - VGA_HV_In) >> 1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lpix_q  <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lpix_q  <= lpix_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Write pipeline is independent of start so in-flight writes drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) begin
        req_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      req_q[0] <= req_d;
      dat_q[0] <= dat_d;
      for (int i = 1; i < PIPE; i++) begin
        req_q[i] <= req_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign buf_wrreq       = req_q[PIPE-1];
  assign wr_dat          = dat_q[PIPE-1];
  assign buf_sel         = sel_q;
  assign line_done       = done_q;
  assign line_idx        = idx_q;
  assign overflow        = ovf_q;
  assign DDR_WrRow_Start = row_q;
  assign DDR_WrCol_Start = col_q;

endmodule

// File: tb/tb_scaler_wrbuf_ctrl.sv
// Randomised bench for scaler_wrbuf_ctrl against a per-line write schedule.
// Overflow expectations follow SCALER_WRBUF_OVF_EN.
module tb_scaler_wrbuf_ctrl;
  localparam int DW    = 24;
  localparam int NBUF  = 3;
  localparam int BURST = 8;
  localparam int XW    = 11;
  localparam int YW    = 12;
  localparam int PIPE  = 3;
  localparam int SW    = $clog2(NBUF);
  localparam int MAXC  = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            din_valid = 1'b0;
  logic [DW-1:0]   din = '0;
  logic [XW-1:0]   line_pix = '0;
  logic            interlace_flag = 1'b0;
  logic [YW-1:0]   VGA_HV_In = '0;
  logic [YW-1:0]   VGA_VV_In = '0;
  logic [YW-1:0]   VGA_HV_Out = '0;
  logic [YW-1:0]   VGA_VV_Out = '0;
  logic [NBUF-1:0] buf_full = '0;
  logic [XW-1:0]   DDR_WrRow_Start;
  logic [XW-1:0]   DDR_WrCol_Start;
  logic [NBUF-1:0] buf_wrreq;
  logic [DW-1:0]   wr_dat;
  logic [SW-1:0]   buf_sel;
  logic            line_done;
  logic [YW-1:0]   line_idx;
  logic            overflow;

  scaler_wrbuf_ctrl #(
    .DW(DW), .NBUF(NBUF), .BURST(BURST),
    .XW(XW), .YW(YW), .PIPE(PIPE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .din_valid(din_valid), .din(din),
    .line_pix(line_pix), .interlace_flag(interlace_flag),
    .VGA_HV_In(VGA_HV_In), .VGA_VV_In(VGA_VV_In),
    .VGA_HV_Out(VGA_HV_Out), .VGA_VV_Out(VGA_VV_Out),
    .buf_full(buf_full),
    .DDR_WrRow_Start(DDR_WrRow_Start),
    .DDR_WrCol_Start(DDR_WrCol_Start),
    .buf_wrreq(buf_wrreq), .wr_dat(wr_dat),
    .buf_sel(buf_sel), .line_done(line_done),
    .line_idx(line_idx), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit [NBUF-1:0] exp_req [MAXC];
  bit [DW-1:0]   exp_dat [MAXC];
  bit            exp_done [MAXC];

  int m_idx = 0, m_sel = 0;
  int m_row = 0, m_col = 0;
  int pend_row = 0, pend_col = 0;
  bit m_ovf = 0, ovf_set_p = 0, start_p = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int offs(input int o, input int i);
    return (o >= i) ? (((o - i) >> 1) & ((1 << XW) - 1)) : 0;
  endfunction

  task automatic set_sizes(input int hi, input int ho,
                           input int vi, input int vo);
    VGA_HV_In  = YW'(hi);
    VGA_HV_Out = YW'(ho);
    VGA_VV_In  = YW'(vi);
    VGA_VV_Out = YW'(vo);
    pend_col = offs(ho, hi);
    pend_row = offs(vo, vi);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc + PIPE + 2 >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    m_row = pend_row;
    m_col = pend_col;
    if (start_p) begin
      m_idx = 0;
      m_sel = 0;
      m_ovf = 0;
    end else if (ovf_set_p) begin
      m_ovf = 1;
    end
    start_p = 0;
    ovf_set_p = 0;
  endtask

  task automatic check_cycle();
    chk("wrreq", 32'(buf_wrreq), 32'(exp_req[cyc]));
    if (exp_req[cyc] != 0)
      chk("wr_dat", 32'(wr_dat), 32'(exp_dat[cyc]));
    chk("line_done", 32'(line_done), 32'(exp_done[cyc]));
    chk("line_idx", 32'(line_idx), 32'(m_idx));
    chk("buf_sel", 32'(buf_sel), 32'(m_sel));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("row_start", 32'(DDR_WrRow_Start), 32'(m_row));
    chk("col_start", 32'(DDR_WrCol_Start), 32'(m_col));
  endtask

  task automatic clr_inputs();
    start = 1'b0;
    din_valid = 1'b0;
    buf_full = '0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    logic [NBUF-1:0] mask;
    mask = interlace_flag ? '1 : NBUF'(1 << m_sel);
`ifdef SCALER_WRBUF_OVF_EN
    if ((mask & buf_full) != 0) begin
      ovf_set_p = 1;
      return;
    end
`endif
    exp_req[cyc + PIPE] = mask;
    exp_dat[cyc + PIPE] = d;
  endtask

  task automatic do_drop();
`ifdef SCALER_WRBUF_OVF_EN
    ovf_set_p = 1;
`endif
  endtask

  task automatic idle(input int n, input bit resize);
    for (int i = 0; i < n; i++) begin
      tick();
      check_cycle();
      clr_inputs();
      if (resize && i == 0)
        set_sizes($urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095));
    end
  endtask

  // One line: n accepted pixels with random gaps, then padding, then switch.
  task automatic run_line(input int n, input bit il,
                          input int full_lo, input int full_hi,
                          input int abort_at);
    int len, sent;
    len = ((n + BURST - 1) / BURST) * BURST;
    sent = 0;
    interlace_flag = il;
    while (sent < n) begin
      tick();
      check_cycle();
      clr_inputs();
      line_pix = (sent == 0) ? XW'(n) : XW'($urandom_range(1, 2000));
      if (sent == abort_at) begin
        start = 1'b1;
        din_valid = 1'b1;
        din = DW'($urandom);
        start_p = 1;
        return;
      end
      if (sent + 1 >= full_lo && sent + 1 <= full_hi)
        buf_full = NBUF'(1);
      if ($urandom_range(0, 3) != 0) begin
        din_valid = 1'b1;
        din = DW'($urandom);
        do_write(din);
        sent++;
      end
    end
    for (int p = 0; p < len - n; p++) begin
      tick();
      check_cycle();
      clr_inputs();
      din_valid = 1'($urandom_range(0, 1));
      din = DW'($urandom);
      if (din_valid) do_drop();
      do_write('0);
    end
    tick();
    m_idx = (m_idx + 1) % (1 << YW);
    m_sel = (m_sel + 1) % NBUF;
    exp_done[cyc] = 1;
    check_cycle();
    clr_inputs();
    din_valid = 1'($urandom_range(0, 1));
    if (din_valid) do_drop();
  endtask

  initial begin
    set_sizes(800, 1024, 600, 480);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wrreq", 32'(buf_wrreq), 0);
    chk("rst_wr_dat", 32'(wr_dat), 0);
    chk("rst_line_done", 32'(line_done), 0);
    chk("rst_line_idx", 32'(line_idx), 0);
    chk("rst_buf_sel", 32'(buf_sel), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_row", 32'(DDR_WrRow_Start), 0);
    chk("rst_col", 32'(DDR_WrCol_Start), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    idle(2, 0);
    chk("col_800_1024", 32'(DDR_WrCol_Start), 112);
    chk("row_out_lt_in", 32'(DDR_WrRow_Start), 0);

    // line_pix == 0 must never start a line
    for (int i = 0; i < 4; i++) begin
      tick();
      check_cycle();
      clr_inputs();
      line_pix = '0;
      din_valid = 1'b1;
      din = DW'($urandom);
    end
    idle(PIPE + 1, 0);

    run_line(16, 0, 0, 0, -1);
    idle(1, 0);
    chk("sel_after_16", 32'(buf_sel), 1);
    run_line(13, 0, 0, 0, -1);
    run_line(5, 0, 0, 0, -1);
    run_line(8, 0, 0, 0, -1);
    idle(PIPE + 1, 0);
    chk("idx_after_4", 32'(line_idx), 4);
    chk("sel_after_4", 32'(buf_sel), 1);

    run_line(20, 1, 0, 0, -1);
    run_line(1, 1, 0, 0, -1);

    run_line(20, 0, 0, 0, 5);
    idle(PIPE + 2, 0);
    chk("abort_sel", 32'(buf_sel), 0);
    chk("abort_idx", 32'(line_idx), 0);

    run_line(12, 0, 3, 4, -1);
    idle(PIPE + 2, 0);
    run_line(13, 0, 0, 0, -1);

    for (int l = 0; l < 30; l++) begin
      if ($urandom_range(0, 7) == 0)
        run_line($urandom_range(2, 30), 0, 0, 0,
                 $urandom_range(1, 2));
      else
        run_line($urandom_range(1, 40), 1'($urandom_range(0, 3) == 0),
                 $urandom_range(0, 20), $urandom_range(0, 20), -1);
      idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    idle(PIPE + 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
